// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction-timer round controller: round state
// encoding and the default reaction-score width.
package reaction_pkg;

  localparam int SCORE_W_DEF = 13;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_DELAY = 3'd1,
    MEASURE    = 3'd2,
    DONE       = 3'd3,
    FOUL       = 3'd4
  } state_e;

endpackage

// File: rtl/sat_score_counter.sv
// Saturating up-counter for the reaction score: Clear has priority over Inc,
// result visible one cycle after the request, holds at all-ones instead of wrapping.
module sat_score_counter #(
  parameter int SCORE_W = 13
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Clear,
  input  logic               Inc,
  output logic [SCORE_W-1:0] Count,
  output logic               Max
);

  logic [SCORE_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (Clear) begin
      count_d = '0;
    end else if (Inc && !Max) begin
      count_d = count_q + SCORE_W'(1);
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign Count = count_q;
  assign Max   = &count_q;

endmodule

// File: rtl/reaction_round_ctrl.sv
// Reaction-timer round FSM: button edges act on the next clock, outputs held in DONE/FOUL
// until the next Start edge. Optional BestScore register when BEST_SCORE_EN is defined.
module reaction_round_ctrl
  import reaction_pkg::*;
#(
  parameter int SCORE_W = SCORE_W_DEF
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Start,
  input  logic               React,
  input  logic               Tick,
  input  logic               DelayDone,
  output logic               DelayEnable,
  output logic               LedOn,
  output logic [SCORE_W-1:0] Score,
  output logic               ScoreValid,
  output logic               Foul,
  output logic               Timeout
`ifdef BEST_SCORE_EN
  ,
  output logic [SCORE_W-1:0] BestScore
`endif
);

  state_e state_q, state_d;
  logic   start_prev_q, start_prev_d;
  logic   react_prev_q, react_prev_d;
  logic   valid_q, valid_d;
  logic   foul_q, foul_d;
  logic   timeout_q, timeout_d;
  logic   start_edge, react_edge;
  logic   cnt_clear, cnt_inc, cnt_max;

  assign start_edge = Start & ~start_prev_q;
  assign react_edge = React & ~react_prev_q;

  // Edge registers reset high so a button held through reset is not an edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      start_prev_q <= 1'b1;
      react_prev_q <= 1'b1;
      valid_q      <= 1'b0;
      foul_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      react_prev_q <= react_prev_d;
      valid_q      <= valid_d;
      foul_q       <= foul_d;
      timeout_q    <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, FOUL: if (start_edge) state_d = WAIT_DELAY;
      WAIT_DELAY: begin
        if (react_edge)     state_d = FOUL;
        else if (DelayDone) state_d = MEASURE;
      end
      MEASURE: if (react_edge || (Tick && cnt_max)) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    DelayEnable = (state_q == WAIT_DELAY);
    LedOn       = (state_q == MEASURE);
  end

  always_comb begin
    start_prev_d = Start;
    react_prev_d = React;
    valid_d      = valid_q;
    foul_d       = foul_q;
    timeout_d    = timeout_q;
    cnt_clear    = 1'b0;
    cnt_inc      = 1'b0;
    case (state_q)
      IDLE, DONE, FOUL: begin
        if (start_edge) begin
          valid_d   = 1'b0;
          foul_d    = 1'b0;
          timeout_d = 1'b0;
          cnt_clear = 1'b1;
        end
      end
      WAIT_DELAY: begin
        if (react_edge)     foul_d    = 1'b1;
        else if (DelayDone) cnt_clear = 1'b1;
      end
      MEASURE: begin
        // A React edge freezes the score; a coincident Tick is dropped.
        if (react_edge) begin
          valid_d = 1'b1;
        end else if (Tick) begin
          if (cnt_max) begin
            valid_d   = 1'b1;
            timeout_d = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  sat_score_counter #(
    .SCORE_W(SCORE_W)
  ) u_score (
    .Clock(Clock),
    .Reset(Reset),
    .Clear(cnt_clear),
    .Inc  (cnt_inc),
    .Count(Score),
    .Max  (cnt_max)
  );

  assign ScoreValid = valid_q;
  assign Foul       = foul_q;
  assign Timeout    = timeout_q;

`ifdef BEST_SCORE_EN
  logic [SCORE_W-1:0] best_q, best_d;

  // Only a React-terminated round can improve the record.
  always_comb begin
    best_d = best_q;
    if ((state_q == MEASURE) && react_edge && (Score < best_q)) best_d = Score;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      best_q <= '1;
    end else begin
      best_q <= best_d;
    end
  end

  assign BestScore = best_q;
`endif

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Bench for reaction_round_ctrl: a 13-bit instance for round behaviour and a
// 4-bit instance sharing the same inputs for score saturation.
module tb_reaction_round_ctrl;

  localparam int W  = 13;
  localparam int W4 = 4;

  logic          Clock = 1'b0;
  logic          Reset, Start, React, Tick, DelayDone;
  logic          DelayEnable, LedOn, ScoreValid, Foul, Timeout;
  logic [W-1:0]  Score;
  logic          DelayEnable4, LedOn4, ScoreValid4, Foul4, Timeout4;
  logic [W4-1:0] Score4;
`ifdef BEST_SCORE_EN
  logic [W-1:0]  BestScore;
  logic [W4-1:0] BestScore4;
  logic [W-1:0]  exp_best;
`endif

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  reaction_round_ctrl #(.SCORE_W(W)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .React(React), .Tick(Tick),
    .DelayDone(DelayDone), .DelayEnable(DelayEnable), .LedOn(LedOn), .Score(Score),
    .ScoreValid(ScoreValid), .Foul(Foul), .Timeout(Timeout)
`ifdef BEST_SCORE_EN
    , .BestScore(BestScore)
`endif
  );

  reaction_round_ctrl #(.SCORE_W(W4)) dut4 (
    .Clock(Clock), .Reset(Reset), .Start(Start), .React(React), .Tick(Tick),
    .DelayDone(DelayDone), .DelayEnable(DelayEnable4), .LedOn(LedOn4), .Score(Score4),
    .ScoreValid(ScoreValid4), .Foul(Foul4), .Timeout(Timeout4)
`ifdef BEST_SCORE_EN
    , .BestScore(BestScore4)
`endif
  );

  function automatic logic [W+4:0] st(input logic de, input logic led, input logic v,
                                      input logic f, input logic t, input logic [W-1:0] s);
    return {de, led, v, f, t, s};
  endfunction

  function automatic logic [W+4:0] got();
    return {DelayEnable, LedOn, ScoreValid, Foul, Timeout, Score};
  endfunction

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Start = 1'b0; React = 1'b0; Tick = 1'b0; DelayDone = 1'b0;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    step();
`ifdef BEST_SCORE_EN
    exp_best = '1;
`endif
  endtask

  // One complete round: Start, `delay` WAIT cycles, `nticks` counted Ticks, React.
  task automatic run_round(input int delay, input int nticks, input bit tick_on_react);
    int   de_cnt, led_cnt, t;
    logic tk;
    Start = 1'b1;
    step();
    Start = 1'b0;
    checks++;
    if (got() !== st(1, 0, 0, 0, 0, '0))
      begin errors++; $display("FAIL round_enter: got %h expected %h", got(), st(1, 0, 0, 0, 0, '0)); end
    de_cnt = 0; led_cnt = 0;
    for (int i = 0; i < delay; i++) begin
      if (DelayEnable) de_cnt++;
      if (LedOn) led_cnt++;
      Start     = 1'($urandom_range(0, 1));
      Tick      = 1'($urandom_range(0, 1));
      DelayDone = (i == delay - 1);
      step();
    end
    DelayDone = 1'b0;
    checks++;
    if (de_cnt !== delay || led_cnt !== 0)
      begin errors++; $display("FAIL wait_len: got de=%0d led=%0d expected de=%0d led=0", de_cnt, led_cnt, delay); end
    checks++;
    if (got() !== st(0, 1, 0, 0, 0, '0))
      begin errors++; $display("FAIL measure_enter: got %h expected %h", got(), st(0, 1, 0, 0, 0, '0)); end
    t = 0;
    while (t < nticks) begin
      tk        = ($urandom_range(0, 2) != 0);
      Tick      = tk;
      Start     = 1'($urandom_range(0, 1));
      DelayDone = 1'($urandom_range(0, 1));
      step();
      if (tk) t++;
      checks++;
      if (got() !== st(0, 1, 0, 0, 0, W'(t)))
        begin errors++; $display("FAIL measure_count: got %h expected %h", got(), st(0, 1, 0, 0, 0, W'(t))); end
    end
    Tick = tick_on_react; Start = 1'b0; DelayDone = 1'b0; React = 1'b1;
    step();
    checks++;
    if (got() !== st(0, 0, 1, 0, 0, W'(nticks)))
      begin errors++; $display("FAIL round_done: got %h expected %h", got(), st(0, 0, 1, 0, 0, W'(nticks))); end
`ifdef BEST_SCORE_EN
    if (W'(nticks) < exp_best) exp_best = W'(nticks);
    checks++;
    if (BestScore !== exp_best)
      begin errors++; $display("FAIL best_model: got %0d expected %0d", BestScore, exp_best); end
`endif
    for (int i = 0; i < 4; i++) begin
      React = 1'($urandom_range(0, 1)); Tick = 1'($urandom_range(0, 1));
      DelayDone = 1'($urandom_range(0, 1));
      step();
      checks++;
      if (got() !== st(0, 0, 1, 0, 0, W'(nticks)))
        begin errors++; $display("FAIL done_hold: got %h expected %h", got(), st(0, 0, 1, 0, 0, W'(nticks))); end
    end
    React = 1'b0; Tick = 1'b0; DelayDone = 1'b0;
    step();
  endtask

  // False start after k WAIT cycles; with_done puts DelayDone in the React cycle.
  task automatic test_foul(input int k, input bit with_done);
    int led_cnt;
    led_cnt = 0;
    Start = 1'b1;
    step();
    Start = 1'b0;
    for (int i = 0; i < k; i++) begin
      if (LedOn) led_cnt++;
      Tick = 1'($urandom_range(0, 1));
      step();
    end
    React = 1'b1; DelayDone = with_done;
    step();
    checks++;
    if (got() !== st(0, 0, 0, 1, 0, '0))
      begin errors++; $display("FAIL foul_enter: got %h expected %h", got(), st(0, 0, 0, 1, 0, '0)); end
    for (int i = 0; i < 4; i++) begin
      if (LedOn) led_cnt++;
      React = 1'($urandom_range(0, 1)); Tick = 1'($urandom_range(0, 1));
      DelayDone = 1'($urandom_range(0, 1));
      step();
      checks++;
      if (got() !== st(0, 0, 0, 1, 0, '0))
        begin errors++; $display("FAIL foul_hold: got %h expected %h", got(), st(0, 0, 0, 1, 0, '0)); end
    end
    checks++;
    if (led_cnt !== 0)
      begin errors++; $display("FAIL foul_led: got %0d lamp cycles expected 0", led_cnt); end
    React = 1'b0; Tick = 1'b0; DelayDone = 1'b0;
    step();
  endtask

  task automatic test_reset();
    Start = 1'b1; React = 1'b1; Tick = 1'b1; DelayDone = 1'b1;
    Reset = 1'b1;
    step();
    checks++;
    if (got() !== st(0, 0, 0, 0, 0, '0))
      begin errors++; $display("FAIL reset_state: got %h expected %h", got(), st(0, 0, 0, 0, 0, '0)); end
`ifdef BEST_SCORE_EN
    checks++;
    if (BestScore !== {W{1'b1}})
      begin errors++; $display("FAIL reset_best: got %h expected %h", BestScore, {W{1'b1}}); end
`endif
    do_reset();
  endtask

  task automatic test_held_react();
    Start = 1'b0; Tick = 1'b0; DelayDone = 1'b0; React = 1'b1;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    step();
`ifdef BEST_SCORE_EN
    exp_best = '1;
`endif
    Start = 1'b1;
    step();
    Start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    DelayDone = 1'b1;
    step();
    DelayDone = 1'b0;
    checks++;
    if (got() !== st(0, 1, 0, 0, 0, '0))
      begin errors++; $display("FAIL held_no_foul: got %h expected %h", got(), st(0, 1, 0, 0, 0, '0)); end
    Tick = 1'b1;
    for (int i = 0; i < 3; i++) step();
    Tick = 1'b0; React = 1'b0;
    step();
    checks++;
    if (got() !== st(0, 1, 0, 0, 0, W'(3)))
      begin errors++; $display("FAIL held_no_stop: got %h expected %h", got(), st(0, 1, 0, 0, 0, W'(3))); end
    React = 1'b1;
    step();
    checks++;
    if (got() !== st(0, 0, 1, 0, 0, W'(3)))
      begin errors++; $display("FAIL held_repress: got %h expected %h", got(), st(0, 0, 1, 0, 0, W'(3))); end
    React = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    Start = 1'b1;
    step();
    Start = 1'b0;
    step();
    DelayDone = 1'b1;
    step();
    DelayDone = 1'b0; Tick = 1'b1;
    for (int i = 0; i < 9; i++) step();
    Tick = 1'b0;
    checks++;
    if (got() !== st(0, 1, 0, 0, 0, W'(9)))
      begin errors++; $display("FAIL mid_setup: got %h expected %h", got(), st(0, 1, 0, 0, 0, W'(9))); end
    Reset = 1'b1;
    #1;
    checks++;
    if (got() !== st(0, 0, 0, 0, 0, '0))
      begin errors++; $display("FAIL mid_async_reset: got %h expected %h", got(), st(0, 0, 0, 0, 0, '0)); end
    step();
    Reset = 1'b0;
    step();
    checks++;
    if (got() !== st(0, 0, 0, 0, 0, '0))
      begin errors++; $display("FAIL mid_idle_after: got %h expected %h", got(), st(0, 0, 0, 0, 0, '0)); end
`ifdef BEST_SCORE_EN
    exp_best = '1;
`endif
  endtask

  task automatic test_timeout();
    logic [W4+4:0] g4;
    do_reset();
    Start = 1'b1;
    step();
    Start = 1'b0; DelayDone = 1'b1;
    step();
    DelayDone = 1'b0; Tick = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      step();
      g4 = {DelayEnable4, LedOn4, ScoreValid4, Foul4, Timeout4, Score4};
      checks++;
      if (g4 !== {5'b01000, W4'(i)})
        begin errors++; $display("FAIL sat_count: got %h expected %h", g4, {5'b01000, W4'(i)}); end
    end
    for (int i = 0; i < 4; i++) begin
      React = (i == 3);
      step();
      g4 = {DelayEnable4, LedOn4, ScoreValid4, Foul4, Timeout4, Score4};
      checks++;
      if (g4 !== {5'b00101, 4'hF})
        begin errors++; $display("FAIL sat_timeout: got %h expected %h", g4, {5'b00101, 4'hF}); end
    end
`ifdef BEST_SCORE_EN
    checks++;
    if (BestScore4 !== 4'hF)
      begin errors++; $display("FAIL sat_best: got %h expected f", BestScore4); end
`endif
    Tick = 1'b0; React = 1'b0;
    do_reset();
  endtask

  task automatic test_best();
    do_reset();
    run_round(5, 50, 1'b1);
`ifdef BEST_SCORE_EN
    checks++;
    if (BestScore !== W'(50)) begin errors++; $display("FAIL best_r1: got %0d expected 50", BestScore); end
`endif
    run_round(8, 30, 1'b0);
`ifdef BEST_SCORE_EN
    checks++;
    if (BestScore !== W'(30)) begin errors++; $display("FAIL best_r2: got %0d expected 30", BestScore); end
`endif
    test_foul(3, 1'b0);
`ifdef BEST_SCORE_EN
    checks++;
    if (BestScore !== W'(30)) begin errors++; $display("FAIL best_foul: got %0d expected 30", BestScore); end
`endif
    run_round(4, 40, 1'b1);
`ifdef BEST_SCORE_EN
    checks++;
    if (BestScore !== W'(30)) begin errors++; $display("FAIL best_r4: got %0d expected 30", BestScore); end
`endif
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(0, 3) == 0)
        test_foul(int'($urandom_range(0, 10)), 1'($urandom_range(0, 1)));
      else
        run_round(int'($urandom_range(1, 30)), int'($urandom_range(0, 60)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; React = 1'b0; Tick = 1'b0; DelayDone = 1'b0;
`ifdef BEST_SCORE_EN
    exp_best = '1;
`endif
    test_reset();
    run_round(20, 37, 1'b1);
    test_foul(4, 1'b1);
    test_held_react();
    test_reset_mid();
    test_timeout();
    test_best();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
